host_specific_top_tx_to_host: RTL and testbench

HOST_SPECIFIC_TOP_TX_TO_HOST -- requirements
Module: host_specific_top_tx_to_host

---
 rtl/wic_link_pkg.sv | 39 +++
 rtl/bluetooth_decoder.sv | 36 +++
 rtl/host_specific_top_tx_to_host.sv | 110 +++++++++++
 tb/tb_host_specific_top_tx_to_host.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wic_link_pkg.sv
// Shared constants, FSM state encoding and frame-building helpers for the
// BLE-to-UART host link.
package wic_link_pkg;

  localparam logic [15:0] BLE_SYNC      = 16'hA55A;
  localparam logic [15:0] UART_SOF      = 16'h5AA5;
  localparam logic [3:0]  BLE_CMD_RX    = 4'h2;
  localparam logic [15:0] UART_RSP_DATA = 16'h0004;
  localparam logic [15:0] OTP_KEY       = 16'hC3A5;
  localparam logic [7:0]  BLE_MAX_LEN   = 8'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    DEC_LO = 3'd2,
    DEC_HI = 3'd3,
    FRAME  = 3'd4
  } state_e;

  // Payload byte 0 sits in bits [31:24]; bytes at or beyond len are cleared.
  function automatic logic [31:0] maskPayload(input logic [31:0] payload,
                                              input logic [7:0]  len);
    logic [31:0] keep;
    keep = {{8{len > 8'd0}}, {8{len > 8'd1}}, {8{len > 8'd2}}, {8{len > 8'd3}}};
    return payload & keep;
  endfunction

  function automatic logic [1023:0] buildFrame(input logic [7:0]  len,
                                               input logic [31:0] payload);
    logic [1023:0] frame;
    frame            = '0;
    frame[1023:1008] = UART_SOF;
    frame[1007:992]  = UART_RSP_DATA;
    frame[991:984]   = len;
    frame[983:952]   = maskPayload(payload, len);
    return frame;
  endfunction

endpackage

// File: rtl/bluetooth_decoder.sv
// Combinational header/checksum validation of a registered BLE packet.
// The checksum comparison is only active when CHECKSUM_EN is defined.
module bluetooth_decoder
  import wic_link_pkg::*;
(
  input  logic [143:0] pkt_i,
  output logic         pktOk_o,
  output logic         pktErr_o
);

  logic hdrOk;
  logic csumOk;
  logic unused_pad;

  assign unused_pad = ^pkt_i[79:16];

  assign hdrOk = (pkt_i[143:128] == BLE_SYNC)   &&
                 (pkt_i[127:124] == BLE_CMD_RX) &&
                 (pkt_i[123:120] == 4'h0)       &&
                 (pkt_i[119:112] <= BLE_MAX_LEN);

`ifdef CHECKSUM_EN
  logic [15:0] csumSum;
  assign csumSum = pkt_i[143:128] + pkt_i[127:112] + pkt_i[111:96] + pkt_i[95:80];
  assign csumOk  = (csumSum == pkt_i[15:0]);
`else
  // Without the checksum feature the payload words and checksum field play no part in validation.
  logic unused_csum;
  assign unused_csum = ^{pkt_i[111:80], pkt_i[15:0]};
  assign csumOk      = 1'b1;
`endif

  assign pktOk_o  = hdrOk && csumOk;
  assign pktErr_o = ~pktOk_o;

endmodule

// File: rtl/host_specific_top_tx_to_host.sv
// Accepts a BLE packet, validates it, OTP-decrypts the payload and emits a
// host UART frame. Checksum validation is enabled by defining CHECKSUM_EN.
module host_specific_top_tx_to_host
  import wic_link_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [143:0]  ble_packet,
  input  logic          packet_valid,
  input  logic          encrypt_decrypt_passthrough,
  output logic [1023:0] uart_frame,
  output logic          frame_valid,
  output logic          error,
  output logic          done
);

  state_e         state_q, state_d;
  logic [143:0]   pkt_q, pkt_d;
  logic           pass_q, pass_d;
  logic [31:0]    payload_q, payload_d;
  logic [1023:0]  uartFrame_q, uartFrame_d;
  logic           frameValid_q, frameValid_d;
  logic           error_q, error_d;
  logic           done_q, done_d;
  logic           chkOk;
  logic           chkErr;

  bluetooth_decoder u_decoder (
    .pkt_i   (pkt_q),
    .pktOk_o (chkOk),
    .pktErr_o(chkErr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pkt_q        <= '0;
      pass_q       <= 1'b0;
      payload_q    <= '0;
      uartFrame_q  <= '0;
      frameValid_q <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      pass_q       <= pass_d;
      payload_q    <= payload_d;
      uartFrame_q  <= uartFrame_d;
      frameValid_q <= frameValid_d;
      error_q      <= error_d;
      done_q       <= done_d;
    end
  end

  // Payload is captured at accept so the decrypt states can work on it in place.
  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    pass_d       = pass_q;
    payload_d    = payload_q;
    uartFrame_d  = uartFrame_q;
    frameValid_d = 1'b0;
    error_d      = error_q;
    done_d       = done_q;

    case (state_q)
      IDLE: begin
        if (packet_valid) begin
          state_d   = CHECK;
          pkt_d     = ble_packet;
          pass_d    = encrypt_decrypt_passthrough;
          payload_d = ble_packet[111:80];
          error_d   = 1'b0;
          done_d    = 1'b0;
        end
      end
      CHECK: begin
        if (chkOk) begin
          state_d = DEC_LO;
        end else begin
          state_d = IDLE;
          error_d = chkErr;
          done_d  = 1'b1;
        end
      end
      DEC_LO: begin
        if (!pass_q) payload_d[31:16] = payload_q[31:16] ^ OTP_KEY;
        state_d = DEC_HI;
      end
      DEC_HI: begin
        if (!pass_q) payload_d[15:0] = payload_q[15:0] ^ OTP_KEY;
        state_d = FRAME;
      end
      FRAME: begin
        uartFrame_d  = buildFrame(pkt_q[119:112], payload_q);
        frameValid_d = 1'b1;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign uart_frame  = uartFrame_q;
  assign frame_valid = frameValid_q;
  assign error       = error_q;
  assign done        = done_q;

endmodule

// File: tb/tb_host_specific_top_tx_to_host.sv
// Scoreboard bench for host_specific_top_tx_to_host: expectations are queued at
// accept and retired when done rises again.
module tb_host_specific_top_tx_to_host;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [143:0]  blePacket = '0;
   logic          packetValid = 1'b0;
   logic          passthrough = 1'b0;
   logic [1023:0] uartFrame;
   logic          frameValid;
   logic          errorOut;
   logic          doneOut;

   host_specific_top_tx_to_host dut (
      .clk                        (clk),
      .reset                      (reset),
      .ble_packet                 (blePacket),
      .packet_valid               (packetValid),
      .encrypt_decrypt_passthrough(passthrough),
      .uart_frame                 (uartFrame),
      .frame_valid                (frameValid),
      .error                      (errorOut),
      .done                       (doneOut)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to measure accept-to-completion latency
   int cycle = 0;
   always @(posedge clk) cycle = cycle + 1;

   typedef struct {
      bit            isErr;
      logic [1023:0] frame;
      int            acceptCycle;
   } expRec_t;

   expRec_t       expQ[$];
   int            testsRun = 0;
   int            testsFailed = 0;
   logic [1023:0] modelFrame = '0;
   bit            modelErr = 1'b0;
   bit            prevDone = 1'b1;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Builds a packet with a correct checksum over sync/cmd/len/payload words
   function automatic logic [143:0] mkPkt(input logic [15:0] sync, input logic [3:0] cmd,
                                          input logic [3:0] rsvd, input logic [7:0] len,
                                          input logic [31:0] pay);
      logic [15:0] csum;
      csum = sync + {cmd, rsvd, len} + pay[31:16] + pay[15:0];
      return {sync, cmd, rsvd, len, pay, 64'h0, csum};
   endfunction

   function automatic logic [1023:0] mkFrame(input logic [7:0] len, input logic [31:0] pay);
      logic [1023:0] f;
      f            = '0;
      f[1023:1008] = 16'h5AA5;
      f[1007:992]  = 16'h0004;
      f[991:984]   = len;
      f[983:952]   = pay;
      return f;
   endfunction

   // Reference behaviour for arbitrary packets
   task automatic modelPacket(input logic [143:0] pkt, input bit pass,
                              output bit err, output logic [31:0] pay);
      logic [15:0] sum;
      err = (pkt[143:128] != 16'hA55A) || (pkt[127:124] != 4'h2) ||
            (pkt[123:120] != 4'h0) || (pkt[119:112] > 8'd4);
      sum = pkt[143:128] + pkt[127:112] + pkt[111:96] + pkt[95:80];
`ifdef CHECKSUM_EN
      if (sum != pkt[15:0]) err = 1'b1;
`endif
      pay = pass ? pkt[111:80] : (pkt[111:80] ^ 32'hC3A5C3A5);
      for (int i = 0; i < 4; i++)
         if (i >= int'(pkt[119:112])) pay[31-8*i -: 8] = 8'h00;
   endtask

   // Monitor retires one expectation per rising edge of done
   always @(negedge clk) begin
      expRec_t e;
      if (!reset) begin
         prevDone = 1'b1;
      end else begin
         if (doneOut && !prevDone) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_completion", 128'(1), 128'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput("error", 128'(errorOut), 128'(e.isErr));
               checkOutput("frame_valid", 128'(frameValid), 128'(!e.isErr));
               checkOutput("frame_head", uartFrame[1023:896], e.frame[1023:896]);
               checkOutput("frame_tail", 128'(|uartFrame[895:0]), 128'(|e.frame[895:0]));
               checkOutput("latency", 128'(cycle - e.acceptCycle), e.isErr ? 128'(1) : 128'(4));
            end
         end else if (frameValid) begin
            checkOutput("stray_frame_valid", 128'(frameValid), 128'(0));
         end
         prevDone = doneOut;
      end
   end

   task automatic pushExpect(input logic [143:0] pkt, input bit expErr, input logic [31:0] expPay);
      expRec_t e;
      e.isErr       = expErr;
      e.acceptCycle = cycle;
      if (expErr) begin
         e.frame  = modelFrame;
         modelErr = 1'b1;
      end else begin
         modelFrame = mkFrame(pkt[119:112], expPay);
         e.frame    = modelFrame;
         modelErr   = 1'b0;
      end
      expQ.push_back(e);
   endtask

   task automatic waitIdle();
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (doneOut === 1'b1) ok = 1'b1;
      end
      if (!ok) checkOutput("idle_timeout", 128'(0), 128'(1));
   endtask

   task automatic acceptPacket(input logic [143:0] pkt, input bit pass,
                               input bit expErr, input logic [31:0] expPay);
      @(negedge clk);
      blePacket   = pkt;
      passthrough = pass;
      packetValid = 1'b1;
      @(posedge clk);
      #1;
      pushExpect(pkt, expErr, expPay);
      packetValid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [143:0] pkt, input bit pass,
                                input bit expErr, input logic [31:0] expPay);
      waitIdle();
      repeat (2) @(negedge clk);
      checkOutput("error_hold", 128'(errorOut), 128'(modelErr));
      checkOutput("frame_hold", uartFrame[1023:896], modelFrame[1023:896]);
      acceptPacket(pkt, pass, expErr, expPay);
      waitIdle();
   endtask

   task automatic applyRandom();
      logic [143:0] pkt;
      logic [31:0]  pay;
      bit           pass;
      bit           err;
      logic [31:0]  expPay;
      pay  = $urandom;
      pass = 1'($urandom_range(0, 1));
      pkt  = mkPkt(16'hA55A, ($urandom_range(0, 3) == 0) ? 4'h1 : 4'h2, 4'h0,
                   8'($urandom_range(0, 5)), pay);
      modelPacket(pkt, pass, err, expPay);
      applyStimulus(pkt, pass, err, expPay);
   endtask

   initial begin
      logic [143:0] base;
      logic [143:0] pkt;
      logic [143:0] pkt2;

      repeat (3) @(negedge clk);
      checkOutput("reset_frame", uartFrame[1023:896], 128'(0));
      checkOutput("reset_frame_valid", 128'(frameValid), 128'(0));
      checkOutput("reset_error", 128'(errorOut), 128'(0));
      checkOutput("reset_done", 128'(doneOut), 128'(1));
      reset = 1'b1;

      base = mkPkt(16'hA55A, 4'h2, 4'h0, 8'h04, 32'h12345678);
      applyStimulus(base, 1'b0, 1'b0, 32'hD19195DD);
      applyStimulus(base, 1'b1, 1'b0, 32'h12345678);

      pkt = base;
      pkt[15:0] = 16'h2E0B;
`ifdef CHECKSUM_EN
      applyStimulus(pkt, 1'b0, 1'b1, 32'h0);
`else
      applyStimulus(pkt, 1'b0, 1'b0, 32'hD19195DD);
`endif

      pkt = base;
      pkt[143:128] = 16'h5AA5;
      applyStimulus(pkt, 1'b0, 1'b1, 32'h0);
      applyStimulus(mkPkt(16'hA55A, 4'h1, 4'h0, 8'h04, 32'h12345678), 1'b0, 1'b1, 32'h0);
      applyStimulus(mkPkt(16'hA55A, 4'h2, 4'h0, 8'h05, 32'h12345678), 1'b0, 1'b1, 32'h0);
      applyStimulus(mkPkt(16'hA55A, 4'h2, 4'h3, 8'h04, 32'h12345678), 1'b0, 1'b1, 32'h0);

      applyStimulus(mkPkt(16'hA55A, 4'h2, 4'h0, 8'h02, 32'h12345678), 1'b0, 1'b0, 32'hD1910000);
      applyStimulus(mkPkt(16'hA55A, 4'h2, 4'h0, 8'h01, 32'h12345678), 1'b1, 1'b0, 32'h12000000);
      applyStimulus(mkPkt(16'hA55A, 4'h2, 4'h0, 8'h00, 32'h12345678), 1'b0, 1'b0, 32'h00000000);

      for (int i = 0; i < 6; i++) applyRandom();

      // packet_valid held high; a second packet shown during DEC_LO must wait
      pkt2 = mkPkt(16'hA55A, 4'h2, 4'h0, 8'h04, 32'hAABBCCDD);
      waitIdle();
      @(negedge clk);
      blePacket   = base;
      passthrough = 1'b0;
      packetValid = 1'b1;
      @(posedge clk);
      #1;
      pushExpect(base, 1'b0, 32'hD19195DD);
      @(posedge clk);
      #1;
      blePacket = pkt2;
      repeat (3) @(posedge clk);
      @(posedge clk);
      #1;
      pushExpect(pkt2, 1'b0, 32'h691E0F78);
      packetValid = 1'b0;
      waitIdle();

      // Reset during DEC_HI aborts the packet
      waitIdle();
      acceptPacket(mkPkt(16'hA55A, 4'h2, 4'h0, 8'h04, 32'h0BADF00D), 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      expQ.delete();
      modelFrame = '0;
      modelErr   = 1'b0;
      #1;
      checkOutput("abort_frame", uartFrame[1023:896], 128'(0));
      checkOutput("abort_frame_valid", 128'(frameValid), 128'(0));
      checkOutput("abort_error", 128'(errorOut), 128'(0));
      checkOutput("abort_done", 128'(doneOut), 128'(1));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);

      applyStimulus(base, 1'b0, 1'b0, 32'hD19195DD);

      waitIdle();
      repeat (3) @(negedge clk);
      checkOutput("pending_expectations", 128'(expQ.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
